ddr_cmd_scheduler: RTL and testbench

DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

---
 rtl/ddr_cmd_scheduler_if.sv | 31 +++
 rtl/ddr_cmd_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_scheduler_if.sv
// Request/command bundle between two requesters and the DDR command scheduler.
// The scheduler uses the slave side; whoever issues requests and watches commands uses master.
interface ddr_cmd_scheduler_if #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int ROWWIDTH = 17,
  parameter int COLWIDTH = 10
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_we;
  logic [2*BGWIDTH-1:0]  req_bg;
  logic [2*BAWIDTH-1:0]  req_ba;
  logic [2*ROWWIDTH-1:0] req_row;
  logic [2*COLWIDTH-1:0] req_col;
  logic [18:0]           commands;
  logic [BGWIDTH-1:0]    bg;
  logic [BAWIDTH-1:0]    ba;
  logic [ROWWIDTH-1:0]   addr;
  logic                  ref_busy;

  modport master (
    output req_valid, req_we, req_bg, req_ba, req_row, req_col,
    input  req_ready, commands, bg, ba, addr, ref_busy
  );

  modport slave (
    input  req_valid, req_we, req_bg, req_ba, req_row, req_col,
    output req_ready, commands, bg, ba, addr, ref_busy
  );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Two-requester DDR command scheduler: open-row table, tRCD/tRP/tRAS timing and
// periodic all-bank refresh, one command per request step on a one-hot command bus.
module ddr_cmd_scheduler #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int ROWWIDTH = 17,
  parameter int COLWIDTH = 10,
  parameter int T_RCD    = 17,
  parameter int T_RP     = 17,
  parameter int T_RAS    = 32,
  parameter int T_RFC    = 34,
  parameter int T_REFI   = 9360
) (
  input logic                 clk,
  input logic                 rst,
  ddr_cmd_scheduler_if.slave  bus
);

  localparam int BKW      = BGWIDTH + BAWIDTH;
  localparam int NB       = 1 << BKW;
  localparam int WAIT_MAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                            : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int TRAS_W   = $clog2(T_RAS + 1);
  localparam int REFI_W   = $clog2(T_REFI + 1);

  localparam logic [18:0] CMD_ACT = 19'h40000;
  localparam logic [18:0] CMD_PR  = 19'h00080;
  localparam logic [18:0] CMD_PRA = 19'h00040;
  localparam logic [18:0] CMD_RD  = 19'h00020;
  localparam logic [18:0] CMD_REF = 19'h00008;
  localparam logic [18:0] CMD_WR  = 19'h00002;

  // Wait states are entered one cycle after the command, so loads are T-2.
  localparam logic [WAIT_W-1:0] RCD_LOAD  = WAIT_W'(T_RCD - 2);
  localparam logic [WAIT_W-1:0] RP_LOAD   = WAIT_W'(T_RP - 2);
  localparam logic [WAIT_W-1:0] RFC_LOAD  = WAIT_W'(T_RFC - 2);
  localparam logic [TRAS_W-1:0] TRAS_LOAD = TRAS_W'(T_RAS - 1);
  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_REF_PRA,
    S_REF_WAIT_RP,
    S_REF_CMD,
    S_REF_WAIT_RFC
  } state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [TRAS_W-1:0]     tras_q, tras_d;
  logic [REFI_W-1:0]     refi_q, refi_d;
  logic                  ref_pending_q, ref_pending_d;
  logic                  rr_last_q, rr_last_d;
  logic                  lat_we_q, lat_we_d;
  logic [BGWIDTH-1:0]    lat_bg_q, lat_bg_d;
  logic [BAWIDTH-1:0]    lat_ba_q, lat_ba_d;
  logic [ROWWIDTH-1:0]   lat_row_q, lat_row_d;
  logic [COLWIDTH-1:0]   lat_col_q, lat_col_d;
  logic [NB-1:0]         open_vld_q, open_vld_d;
  logic [ROWWIDTH-1:0]   open_row_q [NB];

  logic [1:0]            grant;
  logic                  accept;
  logic                  sel;
  logic                  sel_we;
  logic [BGWIDTH-1:0]    sel_bg;
  logic [BAWIDTH-1:0]    sel_ba;
  logic [ROWWIDTH-1:0]   sel_row;
  logic [COLWIDTH-1:0]   sel_col;
  logic [BKW-1:0]        sel_bank;
  logic [BKW-1:0]        lat_bank;
  logic                  refi_wrap;
  logic                  row_we;
  logic [18:0]           cmd;
  logic [BGWIDTH-1:0]    out_bg;
  logic [BAWIDTH-1:0]    out_ba;
  logic [ROWWIDTH-1:0]   out_addr;

  // Round-robin arbiter: only offers a grant while idle with no refresh waiting.
  always_comb begin
    grant = 2'b00;
    if (!rst && state_q == S_IDLE && !ref_pending_q) begin
      if (bus.req_valid == 2'b11) grant = rr_last_q ? 2'b01 : 2'b10;
      else                        grant = bus.req_valid;
    end
  end

  assign accept   = |grant;
  assign sel      = grant[1];
  assign sel_we   = sel ? bus.req_we[1] : bus.req_we[0];
  assign sel_bg   = sel ? bus.req_bg[2*BGWIDTH-1:BGWIDTH]    : bus.req_bg[BGWIDTH-1:0];
  assign sel_ba   = sel ? bus.req_ba[2*BAWIDTH-1:BAWIDTH]    : bus.req_ba[BAWIDTH-1:0];
  assign sel_row  = sel ? bus.req_row[2*ROWWIDTH-1:ROWWIDTH] : bus.req_row[ROWWIDTH-1:0];
  assign sel_col  = sel ? bus.req_col[2*COLWIDTH-1:COLWIDTH] : bus.req_col[COLWIDTH-1:0];
  assign sel_bank = {sel_bg, sel_ba};
  assign lat_bank = {lat_bg_q, lat_ba_q};
  assign refi_wrap = (refi_q == REFI_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d       = state_q;
    wait_d        = wait_q;
    tras_d        = (tras_q != '0) ? tras_q - 1'b1 : '0;
    refi_d        = refi_wrap ? '0 : refi_q + 1'b1;
    ref_pending_d = ref_pending_q | refi_wrap;
    rr_last_d     = rr_last_q;
    lat_we_d      = lat_we_q;
    lat_bg_d      = lat_bg_q;
    lat_ba_d      = lat_ba_q;
    lat_row_d     = lat_row_q;
    lat_col_d     = lat_col_q;
    open_vld_d    = open_vld_q;
    row_we        = 1'b0;
    cmd           = '0;
    out_bg        = '0;
    out_ba        = '0;
    out_addr      = '0;

    case (state_q)
      S_IDLE: begin
        if (ref_pending_q) begin
          state_d = S_REF_PRA;
        end else if (accept) begin
          rr_last_d = sel;
          lat_we_d  = sel_we;
          lat_bg_d  = sel_bg;
          lat_ba_d  = sel_ba;
          lat_row_d = sel_row;
          lat_col_d = sel_col;
          if (!open_vld_q[sel_bank])                 state_d = S_ACT;
          else if (open_row_q[sel_bank] == sel_row)  state_d = S_CAS;
          else                                       state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (tras_q == '0) begin
          cmd                  = CMD_PR;
          out_bg               = lat_bg_q;
          out_ba               = lat_ba_q;
          open_vld_d[lat_bank] = 1'b0;
          wait_d               = RP_LOAD;
          state_d              = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (wait_q == '0) state_d = S_ACT;
        else              wait_d  = wait_q - 1'b1;
      end
      S_ACT: begin
        cmd                  = CMD_ACT;
        out_bg               = lat_bg_q;
        out_ba               = lat_ba_q;
        out_addr             = lat_row_q;
        open_vld_d[lat_bank] = 1'b1;
        row_we               = 1'b1;
        tras_d               = TRAS_LOAD;
        wait_d               = RCD_LOAD;
        state_d              = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (wait_q == '0) state_d = S_CAS;
        else              wait_d  = wait_q - 1'b1;
      end
      S_CAS: begin
        cmd      = lat_we_q ? CMD_WR : CMD_RD;
        out_bg   = lat_bg_q;
        out_ba   = lat_ba_q;
        out_addr = ROWWIDTH'(lat_col_q);
        state_d  = S_IDLE;
      end
      S_REF_PRA: begin
        // PRA goes out even with every bank closed; it keeps refresh timing uniform.
        if (tras_q == '0) begin
          cmd        = CMD_PRA;
          open_vld_d = '0;
          wait_d     = RP_LOAD;
          state_d    = S_REF_WAIT_RP;
        end
      end
      S_REF_WAIT_RP: begin
        if (wait_q == '0) state_d = S_REF_CMD;
        else              wait_d  = wait_q - 1'b1;
      end
      S_REF_CMD: begin
        cmd           = CMD_REF;
        ref_pending_d = refi_wrap;
        wait_d        = RFC_LOAD;
        state_d       = S_REF_WAIT_RFC;
      end
      S_REF_WAIT_RFC: begin
        if (wait_q == '0) state_d = S_IDLE;
        else              wait_d  = wait_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      tras_q        <= '0;
      refi_q        <= '0;
      ref_pending_q <= 1'b0;
      rr_last_q     <= 1'b1;
      lat_we_q      <= 1'b0;
      lat_bg_q      <= '0;
      lat_ba_q      <= '0;
      lat_row_q     <= '0;
      lat_col_q     <= '0;
      open_vld_q    <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      tras_q        <= tras_d;
      refi_q        <= refi_d;
      ref_pending_q <= ref_pending_d;
      rr_last_q     <= rr_last_d;
      lat_we_q      <= lat_we_d;
      lat_bg_q      <= lat_bg_d;
      lat_ba_q      <= lat_ba_d;
      lat_row_q     <= lat_row_d;
      lat_col_q     <= lat_col_d;
      open_vld_q    <= open_vld_d;
    end
  end

  // NOTE: the row storage is not reset; a row is only ever read when its valid bit, which is reset, says so.
  always_ff @(posedge clk) begin
    if (!rst && row_we) open_row_q[lat_bank] <= lat_row_q;
  end

  assign bus.req_ready = grant;
  assign bus.commands  = cmd;
  assign bus.bg        = out_bg;
  assign bus.ba        = out_ba;
  assign bus.addr      = out_addr;
  assign bus.ref_busy  = ref_pending_q ||
                         (state_q inside {S_REF_PRA, S_REF_WAIT_RP, S_REF_CMD, S_REF_WAIT_RFC});

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Scoreboard bench for ddr_cmd_scheduler: expected commands are queued when a request
// is accepted (or a refresh becomes due) and matched against the command bus every cycle.
module tb_ddr_cmd_scheduler;

  localparam int BGW    = 2;
  localparam int BAW    = 2;
  localparam int ROWW   = 17;
  localparam int COLW   = 10;
  localparam int T_RCD  = 17;
  localparam int T_RP   = 17;
  localparam int T_RAS  = 32;
  localparam int T_RFC  = 34;
  localparam int T_REFI = 100;

  localparam logic [18:0] C_ACT = 19'h40000;
  localparam logic [18:0] C_PR  = 19'h00080;
  localparam logic [18:0] C_PRA = 19'h00040;
  localparam logic [18:0] C_RD  = 19'h00020;
  localparam logic [18:0] C_REF = 19'h00008;
  localparam logic [18:0] C_WR  = 19'h00002;

  typedef struct {
    logic [18:0]     cmd;
    logic [BGW-1:0]  bg;
    logic [BAW-1:0]  ba;
    logic [ROWW-1:0] addr;
    int              cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   acc;
  int   idle_at;
  exp_t exp_q[$];
  exp_t mon_e;

  bit   mv   [16];
  int   mrow [16];
  int   last_act;

  ddr_cmd_scheduler_if #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ROWWIDTH(ROWW), .COLWIDTH(COLW)) bus ();

  ddr_cmd_scheduler #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ROWWIDTH(ROWW), .COLWIDTH(COLW),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [18:0] c, input int bg, input int ba, input int addr, input int at);
    exp_t e;
    e.cmd  = c;
    e.bg   = BGW'(bg);
    e.ba   = BAW'(ba);
    e.addr = ROWW'(addr);
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    last_act = -1000;
  endtask

  // Expected command train for a request accepted in cycle a.
  task automatic model_req(input int a, input bit we, input int bg, input int ba,
                           input int row, input int col);
    int b;
    int act;
    int pr;
    int cas;
    b = bg * 4 + ba;
    if (mv[b] && mrow[b] == row) begin
      cas = a + 1;
    end else begin
      act = a + 1;
      if (mv[b]) begin
        pr = (last_act + T_RAS > a + 1) ? last_act + T_RAS : a + 1;
        push(C_PR, bg, ba, 0, pr);
        act = pr + T_RP;
      end
      push(C_ACT, bg, ba, row, act);
      last_act = act;
      mv[b]    = 1'b1;
      mrow[b]  = row;
      cas      = act + T_RCD;
    end
    push(we ? C_WR : C_RD, bg, ba, col, cas);
  endtask

  // first_idle: first cycle the scheduler sits in IDLE with a refresh pending.
  task automatic model_refresh(input int first_idle, output int idle_cycle);
    int pra;
    int rf;
    pra = (last_act + T_RAS > first_idle + 1) ? last_act + T_RAS : first_idle + 1;
    rf  = pra + T_RP;
    push(C_PRA, 0, 0, 0, pra);
    push(C_REF, 0, 0, 0, rf);
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    idle_cycle = rf + T_RFC;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missed_cmd_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.commands != '0) begin
        check("cmd_onehot", $countones(bus.commands), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", bus.commands, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_code", bus.commands, mon_e.cmd);
          check("cmd_cycle", cyc, mon_e.cyc);
          check("cmd_bg", bus.bg, mon_e.bg);
          check("cmd_ba", bus.ba, mon_e.ba);
          check("cmd_addr", bus.addr, mon_e.addr);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_req(input int idx, input bit we, input int bg, input int ba,
                           input int row, input int col);
    bus.req_we[idx]                = we;
    bus.req_bg[idx*BGW +: BGW]     = BGW'(bg);
    bus.req_ba[idx*BAW +: BAW]     = BAW'(ba);
    bus.req_row[idx*ROWW +: ROWW]  = ROWW'(row);
    bus.req_col[idx*COLW +: COLW]  = COLW'(col);
  endtask

  task automatic issue(input int idx, input bit we, input int bg, input int ba,
                       input int row, input int col, output int acc_cyc);
    acc_cyc = -1;
    @(negedge clk);
    drive_req(idx, we, bg, ba, row, col);
    bus.req_valid[idx] = 1'b1;
    #1;
    for (int n = 0; n < 400; n++) begin
      if (bus.req_ready[idx]) begin
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (acc_cyc < 0) begin
      check("accept_timeout", bus.req_ready[idx], 1);
    end else begin
      check("grant_onehot", bus.req_ready, 64'(1) << idx);
      model_req(acc_cyc, we, bg, ba, row, col);
    end
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_g;
    int last_g;
    int g;
    n_cmp = 0;
    n_err = 0;
    bus.req_valid = 2'b11;
    bus.req_we    = '0;
    bus.req_bg    = '0;
    bus.req_ba    = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    rst = 1'b1;
    model_reset();

    // Held in reset with both requesters valid: everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_commands", bus.commands, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_ref_busy", bus.ref_busy, 0);
    check("rst_bg", bus.bg, 0);
    check("rst_ba", bus.ba, 0);
    check("rst_addr", bus.addr, 0);
    bus.req_valid = 2'b00;
    do_reset(1);

    // Closed-bank read, row hit write, row miss read, then refresh with a bank open.
    issue(0, 1'b0, 1, 2, 'h55, 'h10, acc);
    check("acc_closed_rd", acc, 0);
    issue(0, 1'b1, 1, 2, 'h55, 'h20, acc);
    check("acc_row_hit", acc, 19);
    issue(0, 1'b0, 1, 2, 'h66, 'h30, acc);
    check("acc_row_miss", acc, 21);
    wait_cyc(99);
    check("ref_busy_before_wrap", bus.ref_busy, 0);
    model_refresh(100, idle_at);
    fork
      issue(1, 1'b0, 1, 2, 'h66, 'h40, acc);
      begin
        wait_cyc(100);
        #1;
        check("ref_busy_on_wrap", bus.ref_busy, 1);
        check("ready_blocked_by_ref", bus.req_ready, 0);
        wait_cyc(151);
        check("ref_busy_in_rfc", bus.ref_busy, 1);
        wait_cyc(152);
        check("ref_busy_done", bus.ref_busy, 0);
      end
    join
    check("acc_after_refresh", acc, 152);
    wait_cyc(175);
    check("drain_refresh", exp_q.size(), 0);

    // Reset pulse while waiting tRCD aborts the request and forgets the open row.
    do_reset(2);
    model_reset();
    issue(0, 1'b0, 0, 1, 'h12, 'h3, acc);
    check("acc_before_abort", acc, 0);
    wait_cyc(5);
    rst = 1'b1;
    check("abort_pending_cas", exp_q.size(), 1);
    exp_q.delete();
    model_reset();
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("abort_cmd_in_rst", bus.commands, 0);
    check("abort_ready_in_rst", bus.req_ready, 0);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(0, 1'b0, 0, 1, 'h12, 'h3, acc);
    check("acc_after_abort", acc, 0);
    wait_cyc(25);
    check("drain_abort", exp_q.size(), 0);

    // Refresh wrap coinciding with an accept: the request runs first.
    do_reset(2);
    model_reset();
    wait_cyc(98);
    issue(0, 1'b1, 3, 3, 'h1ab, 'h5, acc);
    check("acc_at_wrap", acc, T_REFI - 1);
    model_refresh(acc + 1 + T_RCD + 1, idle_at);
    wait_cyc(100);
    check("ref_busy_during_req", bus.ref_busy, 1);
    issue(1, 1'b0, 0, 0, 'h2, 'h6, acc);
    check("acc_after_wrap_ref", acc, 183);
    wait_cyc(idle_at + 25);
    check("drain_wrap", exp_q.size(), 0);

    // Round robin with both valid, then requester 1 alone.
    do_reset(2);
    model_reset();
    drive_req(0, 1'b1, 2, 0, 'h7, 'h100);
    drive_req(1, 1'b0, 2, 0, 'h7, 'h200);
    bus.req_valid = 2'b11;
    n_g    = 0;
    last_g = 0;
    for (int k = 0; k < 80 && n_g < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready != 2'b00) begin
        g = int'(bus.req_ready[1]);
        check("rr_onehot", $countones(bus.req_ready), 1);
        check("rr_grant", g, (n_g < 6) ? (n_g % 2) : 1);
        if (n_g >= 6) check("single_interval", cyc - last_g, 2);
        model_req(cyc, (g == 0), 2, 0, 'h7, (g == 0) ? 'h100 : 'h200);
        last_g = cyc;
        n_g++;
        if (n_g == 6) begin
          @(posedge clk);
          #1;
          bus.req_valid[0] = 1'b0;
        end
      end
    end
    check("rr_grant_count", n_g, 10);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_cyc(last_g + 10);
    check("drain_rr", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
